// File: rtl/uart_tx_if.sv
// Host-side byte handshake for the UART transmitter.
// A byte transfers on a clk edge where tx_valid && tx_ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    uart_tx_if.slave                           host,
    output logic                               TX,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_d;
    logic [CNT_W-1:0]    baud_cnt, baud_d;
    logic [2:0]          bit_idx, bit_d;
    logic [7:0]          shift, shift_d;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]   count_d;
    logic [7:0]          head;
    logic                push, pop, bit_end, tx_d, ready_d, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                par_bit, par_d;
`endif

    assign head    = mem[rd_ptr];
    assign push    = host.tx_valid && host.tx_ready;
    assign bit_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next state, datapath updates and next values of the registered outputs
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    shift_d = head;
                    pop     = 1'b1;
                    baud_d  = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d  = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d  = baud_cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (fifo_count != '0) begin
                        shift_d = head;
                        pop     = 1'b1;
                        state_d = START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        case ({push, pop})
            2'b10:   count_d = fifo_count + FCNT_W'(1);
            2'b01:   count_d = fifo_count - FCNT_W'(1);
            default: count_d = fifo_count;
        endcase

        ready_d = (count_d != FCNT_W'(FIFO_DEPTH));
        busy_d  = (state_d != IDLE) || (count_d != '0);
    end

    // Datapath, FIFO pointers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            TX            <= 1'b1;
            tx_busy       <= 1'b0;
            host.tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            baud_cnt      <= baud_d;
            bit_idx       <= bit_d;
            shift         <= shift_d;
            fifo_count    <= count_d;
            TX            <= tx_d;
            tx_busy       <= busy_d;
            host.tx_ready <= ready_d;
`ifdef UART_TX_PARITY_EN
            par_bit       <= par_d;
`endif
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by fifo_count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host.tx_data;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboard of accepted bytes checked against frames decoded from TX.
// Runs with a short bit period so every scenario completes quickly.
module tb_uart_tx;
    localparam int unsigned CLK_FREQ  = 160;
    localparam int unsigned BAUD_RATE = 10;
    localparam int          BD        = 16;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS     = 11;
`else
    localparam int          NBITS     = 10;
`endif
    localparam int          FRAME     = NBITS * BD;
    localparam int          TIMEOUT   = 8 * FRAME;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_line;
    logic       tx_busy;
    logic [2:0] fifo_count;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];

    logic [7:0] rx_d;
    logic       rx_p;
    int         rx_t0, t0a, acc_cyc;
    bit         rx_clean, rx_to;

    uart_tx_if host();

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .host(host),
        .TX(tx_line), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Present a byte at a negedge, hold until accepted, record it as expected.
    task automatic push_byte(input logic [7:0] b);
        int w;
        w = 0;
        host.tx_data  = b;
        host.tx_valid = 1'b1;
        while (host.tx_ready !== 1'b1 && w < TIMEOUT) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        sb.push_back(b);
        host.tx_valid = 1'b0;
    endtask

    // Capture one frame cycle-by-cycle; clean=0 on a glitch or bad start/stop.
    task automatic rx_frame(output logic [7:0] d, output logic p, output int t0,
                            output bit clean, output bit to);
        logic [10:0] bits;
        int w;
        bits = '0; d = '0; p = 1'b0; t0 = 0; clean = 1'b1; to = 1'b0; w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (tx_line !== 1'b0 && w < TIMEOUT);
        if (tx_line !== 1'b0) begin
            to = 1'b1;
            return;
        end
        t0 = cyc;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < BD; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (c == 0) bits[b] = tx_line;
                else if (tx_line !== bits[b]) clean = 1'b0;
            end
        end
        d = bits[8:1];
        p = bits[9];
        if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) clean = 1'b0;
    endtask

    task automatic test_reset();
        host.tx_valid = 1'b0;
        host.tx_data  = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_line !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_line); end
        n_checks++; if (host.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", host.tx_ready); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset tx=%b busy=%b want tx=1 busy=0", tx_line, tx_busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp_b;
        @(negedge clk);
        fork
            begin
                push_byte(8'h32);
                acc_cyc = cyc;
                n_checks++; if (fifo_count !== 3'd1 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_accept count=%0d busy=%b want 1/1", fifo_count, tx_busy); end
                @(negedge clk);
                n_checks++; if (tx_line !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_load tx=%b count=%0d want 0/0", tx_line, fifo_count); end
            end
            rx_frame(rx_d, rx_p, rx_t0, rx_clean, rx_to);
        join
        exp_b = 8'hxx;
        if (sb.size() != 0) exp_b = sb.pop_front();
        n_checks++; if (rx_to || rx_d !== exp_b || !rx_clean) begin n_fail++; $display("FAIL single_data got %h clean=%b to=%b want %h", rx_d, rx_clean, rx_to, exp_b); end
        n_checks++; if (rx_t0 !== acc_cyc + 1) begin n_fail++; $display("FAIL single_latency start at %0d want %0d", rx_t0, acc_cyc + 1); end
`ifdef UART_TX_PARITY_EN
        n_checks++; if (rx_p !== ^exp_b) begin n_fail++; $display("FAIL single_parity got %b want %b", rx_p, ^exp_b); end
`endif
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop got %b want 1", tx_busy); end
        @(negedge clk);
        n_checks++; if (tx_busy !== 1'b0 || cyc - rx_t0 !== FRAME) begin n_fail++; $display("FAIL single_busy_fall busy=%b after %0d want 0 after %0d", tx_busy, cyc - rx_t0, FRAME); end
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] exp_b;
        @(negedge clk);
        fork
            begin
                push_byte(b0);
                push_byte(b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    rx_frame(rx_d, rx_p, rx_t0, rx_clean, rx_to);
                    exp_b = 8'hxx;
                    if (sb.size() != 0) exp_b = sb.pop_front();
                    n_checks++; if (rx_to || rx_d !== exp_b || !rx_clean) begin n_fail++; $display("FAIL b2b_data%0d got %h clean=%b to=%b want %h", k, rx_d, rx_clean, rx_to, exp_b); end
`ifdef UART_TX_PARITY_EN
                    n_checks++; if (rx_p !== ^exp_b) begin n_fail++; $display("FAIL parity%0d got %b want %b", k, rx_p, ^exp_b); end
`endif
                    if (k == 0) t0a = rx_t0;
                end
            end
        join
        n_checks++; if (rx_t0 - t0a !== FRAME) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", rx_t0 - t0a, FRAME); end
    endtask

    task automatic test_full_fifo();
        logic [7:0] exp_b;
        bit saw_full;
        int w;
        saw_full = 1'b0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    host.tx_data  = 8'(16 + i);
                    host.tx_valid = 1'b1;
                    w = 0;
                    while (host.tx_ready !== 1'b1 && w < TIMEOUT) begin
                        if (!saw_full) begin
                            saw_full = 1'b1;
                            n_checks++; if (fifo_count !== 3'd4 || i != 5) begin n_fail++; $display("FAIL full_level count=%0d at byte %0d want 4 at byte 5", fifo_count, i); end
                        end
                        @(negedge clk);
                        w++;
                    end
                    @(negedge clk);
                    sb.push_back(8'(16 + i));
                end
                host.tx_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    rx_frame(rx_d, rx_p, rx_t0, rx_clean, rx_to);
                    exp_b = 8'hxx;
                    if (sb.size() != 0) exp_b = sb.pop_front();
                    n_checks++; if (rx_to || rx_d !== exp_b || !rx_clean) begin n_fail++; $display("FAIL full_data%0d got %h clean=%b to=%b want %h", k, rx_d, rx_clean, rx_to, exp_b); end
                end
            end
        join
        n_checks++; if (!saw_full) begin n_fail++; $display("FAIL full_ready_drop got ready never low want low at count 4"); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_leftover got %0d queued want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b;
        int t0, lows;
        @(negedge clk);
        push_byte(8'h4D);
        push_byte(8'hA5);
        t0 = cyc;
        n_checks++; if (tx_line !== 1'b0) begin n_fail++; $display("FAIL mid_start tx=%b want 0", tx_line); end
        repeat (2 * BD + BD / 2) @(negedge clk);
        n_checks++; if (tx_line !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL mid_bit1 tx=%b count=%0d want 0/1", tx_line, fifo_count); end
        repeat (2 * BD) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (tx_line !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || host.tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset tx=%b count=%0d busy=%b ready=%b want 1/0/0/1", tx_line, fifo_count, tx_busy, host.tx_ready);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx_line !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        n_checks++; if (lows != 0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_no_resume active cycles=%0d count=%0d want 0/0", lows, fifo_count); end
        push_byte(8'h55);
        rx_frame(rx_d, rx_p, rx_t0, rx_clean, rx_to);
        exp_b = 8'hxx;
        if (sb.size() != 0) exp_b = sb.pop_front();
        n_checks++; if (rx_to || rx_d !== exp_b || !rx_clean) begin n_fail++; $display("FAIL mid_recover got %h clean=%b to=%b want %h", rx_d, rx_clean, rx_to, exp_b); end
        n_checks++; if (rx_t0 - t0 <= 0) begin n_fail++; $display("FAIL mid_recover_order start %0d not after %0d", rx_t0, t0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(8'h31, 8'h33);
        test_full_fifo();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_back_to_back(8'h32, 8'h33);
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
